// File: rtl/writeback_unit.sv
// writeback_unit: owns the single write port of the integer register file.
// ALU results win the port; load returns that lose arbitration wait in a
// small FIFO. A pending-load scoreboard lets decode stall on hazards against
// loads that have been issued but not yet written back.
// Optional feature macro: WB_LD_BYPASS_EN. When defined, a load that arrives
// with an empty FIFO and no ALU result goes straight to the output registers.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_ld_issue,
  input  logic [4:0]  i_ld_issue_rd,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_ready,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  output logic        o_hazard,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata,
  output logic        o_write
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  // Load-return FIFO storage
  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  // Scoreboard: bit n set while a load to xn is outstanding; bit 0 stays clear
  logic [31:0]   pend_q, pend_d;

  // Registered write port plus a tag saying the current write came from a load
  logic          write_q, write_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_load_q, wr_load_d;

  logic          fifo_empty_s;
  logic          ld_acc_s;
  logic          alu_wr_s;
  logic          enq_s;
  logic          deq_s;
`ifdef WB_LD_BYPASS_EN
  logic          bypass_s;
`endif

  // Ready looks only at the registered count, so a same-cycle dequeue never raises it
  assign o_ld_ready   = (cnt_q < FULL_CNT);
  assign fifo_empty_s = (cnt_q == {(AW + 1){1'b0}});

  // Returns to x0 are accepted on the bus but carry nothing worth keeping
  assign ld_acc_s = i_ld_valid & o_ld_ready & (i_ld_rd != 5'd0);
  assign alu_wr_s = i_alu_valid & (i_alu_rd != 5'd0);

  // Any ALU valid (even to x0) owns the cycle and holds the FIFO head back
  assign deq_s = ~i_alu_valid & ~fifo_empty_s;

`ifdef WB_LD_BYPASS_EN
  assign bypass_s = ld_acc_s & fifo_empty_s & ~i_alu_valid;
  assign enq_s    = ld_acc_s & ~bypass_s;
`else
  assign enq_s    = ld_acc_s;
`endif

  // Hazard is combinational on the registered scoreboard; pend_q[0] is always 0
  assign o_hazard = pend_q[i_rs1] | pend_q[i_rs2] | pend_q[i_rd];

  assign o_write = write_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;

  // Write-port arbitration: ALU, then FIFO head, then (optionally) the bypassed load
  always_comb begin
    write_d   = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wr_load_d = 1'b0;
    if (alu_wr_s) begin
      write_d   = 1'b1;
      waddr_d   = i_alu_rd;
      wdata_d   = i_alu_data;
      wr_load_d = 1'b0;
    end else if (deq_s) begin
      write_d   = 1'b1;
      waddr_d   = fifo_rd_q[rd_ptr_q];
      wdata_d   = fifo_data_q[rd_ptr_q];
      wr_load_d = 1'b1;
`ifdef WB_LD_BYPASS_EN
    end else if (bypass_s) begin
      write_d   = 1'b1;
      waddr_d   = i_ld_rd;
      wdata_d   = i_ld_data;
      wr_load_d = 1'b1;
`endif
    end else begin
      write_d   = 1'b0;
      wr_load_d = 1'b0;
    end
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq_s, deq_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Scoreboard next-state: clear after a load's write cycle, then set on issue so set wins
  always_comb begin
    pend_d = pend_q;
    if (write_q && wr_load_q) begin
      pend_d[waddr_q] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (i_ld_issue && (i_ld_issue_rd != 5'd0)) begin
      pend_d[i_ld_issue_rd] = 1'b1;
    end else begin
      pend_d[0] = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  // Control state: write port, pointers, count and scoreboard
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      write_q   <= 1'b0;
      waddr_q   <= 5'd0;
      wdata_q   <= 32'd0;
      wr_load_q <= 1'b0;
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      cnt_q     <= {(AW + 1){1'b0}};
      pend_q    <= 32'd0;
    end else begin
      write_q   <= write_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wr_load_q <= wr_load_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
    end
  end

  // FIFO storage: captures an accepted, non-bypassed load at the write pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= 5'd0;
        fifo_data_q[i] <= 32'd0;
      end
    end else if (enq_s) begin
      fifo_rd_q[wr_ptr_q]   <= i_ld_rd;
      fifo_data_q[wr_ptr_q] <= i_ld_data;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: a queue-based reference model predicts
// every register-file write (with its cycle), o_ld_ready and o_hazard; a
// negedge monitor compares the DUT against those predictions.
module tb_writeback_unit;

  localparam int DEPTH = 4;
`ifdef WB_LD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_alu_valid, i_ld_issue, i_ld_valid;
  logic [4:0]  i_alu_rd, i_ld_issue_rd, i_ld_rd, i_rs1, i_rs2, i_rd;
  logic [31:0] i_alu_data, i_ld_data;
  logic        o_ld_ready, o_hazard, o_write;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_ld_issue(i_ld_issue), .i_ld_issue_rd(i_ld_issue_rd),
    .i_ld_valid(i_ld_valid), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
    .o_ld_ready(o_ld_ready),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .o_hazard(o_hazard),
    .o_waddr(o_waddr), .o_wdata(o_wdata), .o_write(o_write)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } wr_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } ld_t;

  wr_t         expq[$];
  ld_t         m_fifo[$];
  logic [31:0] m_pend = 32'd0;
  bit          m_wr_load = 1'b0;
  logic [4:0]  m_wr_rd = 5'd0;
  logic        exp_ready = 1'b1;
  logic        exp_hazard = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          run = 1'b0;
  wr_t         mon_e;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic hit(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r];
  endfunction

  task automatic idle();
    i_alu_valid = 1'b0; i_alu_rd = 5'd0; i_alu_data = 32'd0;
    i_ld_issue = 1'b0; i_ld_issue_rd = 5'd0;
    i_ld_valid = 1'b0; i_ld_rd = 5'd0; i_ld_data = 32'd0;
    i_rs1 = 5'd0; i_rs2 = 5'd0; i_rd = 5'd0;
  endtask

  task automatic rnd_inputs();
    i_alu_valid = 1'($urandom); i_alu_rd = 5'($urandom); i_alu_data = $urandom;
    i_ld_issue = 1'($urandom); i_ld_issue_rd = 5'($urandom);
    i_ld_valid = 1'($urandom); i_ld_rd = 5'($urandom); i_ld_data = $urandom;
    i_rs1 = 5'($urandom); i_rs2 = 5'($urandom); i_rd = 5'($urandom);
  endtask

  // One clock cycle: predict from the current inputs, advance, commit the model.
  task automatic tick();
    ld_t         nf[$];
    ld_t         h;
    wr_t         e;
    logic [31:0] pn;
    bit          acc, byp_now, nload;
    logic [4:0]  nrd;
    nf = m_fifo;
    exp_ready  = (m_fifo.size() < DEPTH);
    exp_hazard = hit(i_rs1) | hit(i_rs2) | hit(i_rd);
    acc = i_ld_valid && exp_ready && (i_ld_rd != 5'd0);
    byp_now = 1'b0; nload = 1'b0; nrd = 5'd0;
    if (i_alu_valid && i_alu_rd != 5'd0) begin
      e.cyc = cyc + 1; e.rd = i_alu_rd; e.data = i_alu_data;
      expq.push_back(e);
    end else if (!i_alu_valid && nf.size() > 0) begin
      h = nf.pop_front();
      e.cyc = cyc + 1; e.rd = h.rd; e.data = h.data;
      expq.push_back(e);
      nload = 1'b1; nrd = h.rd;
    end else if (BYP && !i_alu_valid && acc) begin
      e.cyc = cyc + 1; e.rd = i_ld_rd; e.data = i_ld_data;
      expq.push_back(e);
      nload = 1'b1; nrd = i_ld_rd; byp_now = 1'b1;
    end
    if (acc && !byp_now) begin
      h.rd = i_ld_rd; h.data = i_ld_data;
      nf.push_back(h);
    end
    pn = m_pend;
    if (m_wr_load) pn[m_wr_rd] = 1'b0;
    if (i_ld_issue && i_ld_issue_rd != 5'd0) pn[i_ld_issue_rd] = 1'b1;
    @(posedge i_clk);
    #1;
    m_fifo = nf; m_pend = pn; m_wr_load = nload; m_wr_rd = nrd;
  endtask

  // Asynchronous reset between clock edges, with checks before any edge arrives.
  task automatic do_reset(input logic [4:0] probe);
    #1;
    rnd_inputs(); i_rs1 = probe;
    i_rst_n = 1'b0;
    #1;
    chk("rst_write", 32'(o_write), 32'd0);
    chk("rst_waddr", 32'(o_waddr), 32'd0);
    chk("rst_wdata", o_wdata, 32'd0);
    chk("rst_ready", 32'(o_ld_ready), 32'd1);
    chk("rst_hazard", 32'(o_hazard), 32'd0);
    expq.delete(); m_fifo.delete();
    m_pend = 32'd0; m_wr_load = 1'b0; exp_ready = 1'b1; exp_hazard = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    rnd_inputs(); i_rs1 = probe;
    #1;
    chk("rst_hold_write", 32'(o_write), 32'd0);
    chk("rst_hold_ready", 32'(o_ld_ready), 32'd1);
    chk("rst_hold_hazard", 32'(o_hazard), 32'd0);
    #1;
    idle();
    i_rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes, checks ready/hazard every cycle
  always @(negedge i_clk) begin
    if (run && i_rst_n) begin
      chk("ld_ready", 32'(o_ld_ready), 32'(exp_ready));
      chk("hazard", 32'(o_hazard), 32'(exp_hazard));
      if (o_write === 1'b1) begin
        if (expq.size() == 0) begin
          chk("spurious_write", 32'(o_write), 32'd0);
        end else begin
          mon_e = expq.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("waddr", 32'(o_waddr), 32'(mon_e.rd));
          chk("wdata", o_wdata, mon_e.data);
        end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        void'(expq.pop_front());
        chk("write_missing", 32'(o_write), 32'd1);
      end
    end
  end

  initial begin : main
    bit [31:0] outst;
    bit        found;
    int        r;
    int        r2;
    idle();
    do_reset(5'd0);
    run = 1'b1;

    // ALU path
    idle(); i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF; tick();
    chk("alu_write", 32'(o_write), 32'd1);
    chk("alu_waddr", 32'(o_waddr), 32'd5);
    chk("alu_wdata", o_wdata, 32'hDEADBEEF);
    idle(); i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'h11111111; tick();
    chk("alu_x0_nowrite", 32'(o_write), 32'd0);
    idle(); tick();

    // Collision: ALU rd=3 and load return rd=7 in the same cycle
    idle(); i_ld_issue = 1'b1; i_ld_issue_rd = 5'd7; tick();
    idle(); i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'hA5A5A5A5;
    i_ld_valid = 1'b1; i_ld_rd = 5'd7; i_ld_data = 32'h00001234; i_rs1 = 5'd7; tick();
    chk("col_n1_waddr", 32'(o_waddr), 32'd3);
    chk("col_n1_hazard", 32'(o_hazard), 32'd1);
    idle(); i_rs1 = 5'd7; tick();
    chk("col_n2_waddr", 32'(o_waddr), 32'd7);
    chk("col_n2_wdata", o_wdata, 32'h00001234);
    chk("col_n2_hazard", 32'(o_hazard), 32'd1);
    tick();
    chk("col_n3_hazard", 32'(o_hazard), 32'd0);
    idle(); tick();

    // Full FIFO under sustained ALU traffic, then drain in order
    for (int i = 0; i < 5; i++) begin
      idle(); i_ld_issue = 1'b1; i_ld_issue_rd = 5'(10 + i); tick();
    end
    for (int i = 0; i < 5; i++) begin
      idle(); i_alu_valid = 1'b1; i_alu_rd = 5'(20 + i); i_alu_data = $urandom;
      i_ld_valid = 1'b1; i_ld_rd = 5'(10 + i); i_ld_data = $urandom; tick();
      if (i >= 3) chk("full_ready_low", 32'(o_ld_ready), 32'd0);
    end
    idle();
    repeat (7) tick();

    // Reset while the FIFO holds loads and the scoreboard is populated
    idle(); i_ld_issue = 1'b1; i_ld_issue_rd = 5'd15; tick();
    idle(); i_ld_issue = 1'b1; i_ld_issue_rd = 5'd16; tick();
    idle(); i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_ld_valid = 1'b1; i_ld_rd = 5'd15; i_ld_data = 32'hCAFE0015; tick();
    idle(); i_alu_valid = 1'b1; i_alu_rd = 5'd2; i_ld_valid = 1'b1; i_ld_rd = 5'd16; i_ld_data = 32'hCAFE0016; tick();
    idle(); i_alu_valid = 1'b1; i_alu_rd = 5'd6; i_rs1 = 5'd15; tick();
    chk("pre_rst_hazard", 32'(o_hazard), 32'd1);
    do_reset(5'd15);

    // Lone load return: bypass latency 1, otherwise 2
    idle(); i_ld_issue = 1'b1; i_ld_issue_rd = 5'd9; tick();
    idle(); tick();
    idle(); i_ld_valid = 1'b1; i_ld_rd = 5'd9; i_ld_data = 32'h90909090; tick();
    chk("byp_n1_write", 32'(o_write), BYP ? 32'd1 : 32'd0);
    idle(); tick();
    chk("byp_n2_write", 32'(o_write), BYP ? 32'd0 : 32'd1);
    idle(); tick();

    // Re-issue rd=4 in the write cycle of the previous rd=4 load: pending must stay set
    idle(); i_ld_issue = 1'b1; i_ld_issue_rd = 5'd4; tick();
    idle(); tick();
    idle(); i_ld_valid = 1'b1; i_ld_rd = 5'd4; i_ld_data = 32'h44444444; tick();
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (o_write === 1'b1 && o_waddr == 5'd4) begin
        found = 1'b1;
        break;
      end
      idle(); tick();
    end
    chk("sb_edge_found", 32'(found), 32'd1);
    idle(); i_ld_issue = 1'b1; i_ld_issue_rd = 5'd4; i_rs1 = 5'd4; tick();
    chk("sb_edge_set_wins", 32'(o_hazard), 32'd1);
    idle(); i_rs1 = 5'd4; tick();
    chk("sb_edge_still_set", 32'(o_hazard), 32'd1);
    idle(); i_ld_valid = 1'b1; i_ld_rd = 5'd4; i_ld_data = 32'h44440002; i_rs1 = 5'd4; tick();
    idle(); i_rs1 = 5'd4;
    repeat (3) tick();
    chk("sb_edge_cleared", 32'(o_hazard), 32'd0);

    // Randomized traffic obeying the decode contract (mostly honouring o_ld_ready)
    outst = 32'd0;
    for (int n = 0; n < 2500; n++) begin
      idle();
      i_alu_valid = ($urandom_range(0, 2) == 0);
      i_alu_rd    = 5'($urandom_range(0, 31));
      i_alu_data  = $urandom;
      r = $urandom_range(0, 31);
      if ($urandom_range(0, 2) == 0 && !m_pend[r] && !outst[r]) begin
        i_ld_issue = 1'b1; i_ld_issue_rd = 5'(r);
      end
      i_ld_data = $urandom;
      if ($urandom_range(0, 31) == 0) begin
        i_ld_valid = 1'b1; i_ld_rd = 5'd0;
      end else if (outst != 32'd0 && $urandom_range(0, 1) == 1) begin
        for (int t = 0; t < 16; t++) begin
          r2 = $urandom_range(1, 31);
          if (outst[r2]) begin
            i_ld_valid = 1'b1; i_ld_rd = 5'(r2);
            break;
          end
        end
        if (i_ld_valid && !(m_fifo.size() < DEPTH) && $urandom_range(0, 7) != 0) i_ld_valid = 1'b0;
        if (i_ld_valid && m_fifo.size() < DEPTH) outst[i_ld_rd] = 1'b0;
      end
      if (i_ld_issue && i_ld_issue_rd != 5'd0) outst[i_ld_issue_rd] = 1'b1;
      i_rs1 = 5'($urandom); i_rs2 = 5'($urandom); i_rd = 5'($urandom);
      tick();
    end

    idle();
    repeat (12) tick();
    chk("drain_empty", 32'(expq.size()), 32'd0);

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
